// File: rtl/accel_pkg.sv
// Register map, CTRL bit positions and FSM state encoding for the accelerator host sequencer.
package accel_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_RESULT = 1;
  localparam int unsigned REG_OPA    = 2;
  localparam int unsigned REG_OPB    = 3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT   = 1;

  localparam logic [31:0] CTRL_START = 32'd1 << CTRL_START_BIT;
  localparam logic [31:0] CTRL_CLR   = 32'd1 << CTRL_CLR_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_START,
    S_WAIT_IRQ,
    S_CLEAR,
    S_RESP
  } state_e;

endpackage

// File: rtl/accel_host_seq.sv
// Sequences one A+B job onto the accelerator register bus: load operands, start,
// wait for done (with timeout), clear done, then hold the result until consumed.
module accel_host_seq
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [31:0]       job_a,
  input  logic [31:0]       job_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_err,
  output logic              bus_wr_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wr_data,
  input  logic [31:0]       bus_rd_data,
  input  logic              bus_irq,
  output logic [15:0]       jobs_done
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic [15:0] jobs_q, jobs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    err_d       = err_q;
    jobs_d      = jobs_q;
    job_ready   = 1'b0;
    res_valid   = 1'b0;
    bus_wr_en   = 1'b0;
    bus_addr    = '0;
    bus_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        // gated so the bench/host never sees ready while reset is held
        job_ready = rst_n;
        if (job_valid) begin
          a_d     = job_a;
          b_d     = job_b;
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        bus_wr_en   = 1'b1;
        bus_addr    = ADDR_W'(REG_OPA);
        bus_wr_data = a_q;
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        bus_wr_en   = 1'b1;
        bus_addr    = ADDR_W'(REG_OPB);
        bus_wr_data = b_q;
        state_d     = S_START;
      end
      S_START: begin
        bus_wr_en   = 1'b1;
        bus_addr    = ADDR_W'(REG_CTRL);
        bus_wr_data = CTRL_START;
        cnt_d       = '0;
        state_d     = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        // irq already high on entry is trusted: RESULT was updated on the start edge
        bus_addr = ADDR_W'(REG_RESULT);
        if (bus_irq) begin
          res_d   = bus_rd_data;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CLEAR: begin
        bus_wr_en   = 1'b1;
        bus_addr    = ADDR_W'(REG_CTRL);
        bus_wr_data = CTRL_CLR;
        state_d     = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_data  = res_q;
  assign res_err   = err_q;
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_accel_host_seq.sv
// Randomized bench for accel_host_seq with a behavioural accelerator and job-level reference.
module tb_accel_host_seq;
  localparam int TO = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [31:0]   job_a = '0, job_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic          res_err;
  logic          bus_wr_en;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wr_data;
  logic [31:0]   bus_rd_data;
  logic          bus_irq;
  logic [15:0]   jobs_done;

  int total = 0;
  int bad = 0;
  int jobs_exp = 0;

  always #5 clk = ~clk;

  accel_host_seq #(.TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .bus_wr_en(bus_wr_en), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_irq(bus_irq), .jobs_done(jobs_done)
  );

  // accelerator model: done rises m_dly cycles after the start write (255 = never)
  logic [31:0] m_opa = '0, m_opb = '0, m_res = '0;
  logic        m_pend = 1'b0;
  int          m_cyc = 0;
  int          m_dly = 0;

  always @(posedge clk) begin
    if (!rst_n) m_pend <= 1'b0;
    else if (bus_wr_en) begin
      case (bus_addr)
        4'd2: m_opa <= bus_wr_data;
        4'd3: m_opb <= bus_wr_data;
        4'd0: begin
          if (bus_wr_data[0]) begin
            m_res  <= m_opa + m_opb;
            m_pend <= 1'b1;
            m_cyc  <= 0;
          end
          if (bus_wr_data[1]) m_pend <= 1'b0;
        end
        default: ;
      endcase
    end else if (m_pend) m_cyc <= m_cyc + 1;
  end

  assign bus_irq = m_pend && (m_cyc >= m_dly);

  always_comb begin
    bus_rd_data = '0;
    case (bus_addr)
      4'd1: bus_rd_data = m_res;
      4'd2: bus_rd_data = m_opa;
      4'd3: bus_rd_data = m_opb;
      default: bus_rd_data = '0;
    endcase
  end

  logic [35:0] wq[$];
  always @(negedge clk) if (rst_n && bus_wr_en) wq.push_back({bus_addr, bus_wr_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int d, input int hold);
    int n, lat, nw, exp_lat;
    logic [31:0] er;
    logic ee;
    logic [3:0]  xa[4];
    logic [31:0] xd[4];
    n = 0;
    while (!job_ready && n < 50) begin @(negedge clk); n++; end
    chk("job_ready", job_ready, 1);
    m_dly = d; job_a = a; job_b = b; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0; job_a = $urandom; job_b = $urandom;
    chk("busy_ready", job_ready, 0);
    lat = 0;
    while (!res_valid && lat < 100) begin @(negedge clk); lat++; end
    exp_lat = (d < TO) ? 5 + d : 4 + TO;
    chk("latency", lat, exp_lat);
    er = (d < TO) ? a + b : 32'd0;
    ee = (d >= TO);
    chk("res_data", res_data, er);
    chk("res_err", res_err, ee);
    nw = wq.size();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      job_valid = 1'b1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, er);
      chk("hold_ready", job_ready, 0);
    end
    job_valid = 1'b0;
    chk("hold_writes", wq.size(), nw);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    jobs_exp++;
    chk("jobs_done", jobs_done, jobs_exp & 16'hFFFF);
    chk("ready_after", job_ready, 1);
    chk("valid_after", res_valid, 0);
    xa = '{4'd2, 4'd3, 4'd0, 4'd0};
    xd = '{a, b, 32'd1, 32'd2};
    chk("nwrites", wq.size(), 4);
    if (wq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("wr_addr", wq[i][35:32], xa[i]);
        chk("wr_data", wq[i][31:0], xd[i]);
      end
    wq.delete();
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_job_ready", job_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_wr_en", bus_wr_en, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wr_data, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_res", res_data, 0);
    chk("rst_err", res_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", job_ready, 1);

    run_job(32'd3, 32'd4, 0, 0);
    run_job(32'hFFFFFFFF, 32'd2, 2, 0);
    run_job(32'd5, 32'd6, 255, 0);
    run_job(32'd7, 32'd8, TO - 1, 0);
    run_job(32'd9, 32'd10, 1, 10);

    // reset while WR_B is on the bus
    m_dly = 0; job_a = 32'd11; job_b = 32'd12; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr", bus_wr_en, 1);
    chk("pre_rst_addr", bus_addr, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", bus_wr_en, 0);
    chk("mid_rst_ready", job_ready, 0);
    chk("mid_rst_addr", bus_addr, 0);
    chk("mid_rst_jobs", jobs_done, 0);
    jobs_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("post_rst_ready", job_ready, 1);
    run_job(32'd1, 32'd1, 0, 0);

    run_job(32'd100, 32'd200, 0, 0);
    for (int k = 0; k < 24; k++)
      run_job($urandom, $urandom, $urandom_range(0, 11), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
endmodule

// File: doc/accel_host_seq.md
ACCEL_HOST_SEQ -- requirements
Module: accel_host_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000, max WAIT_IRQ cycles before abort (range 2..65535).
REQ-002 Parameter ADDR_W, default 4, register-bus address width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 job_valid  input  1  job request.
REQ-006 job_ready  output  1  job accepted when high with job_valid.
REQ-007 job_a  input  32  operand A.
REQ-008 job_b  input  32  operand B.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  result consumed when high with res_valid.
REQ-011 res_data  output  32  result (A+B as computed by accelerator).
REQ-012 res_err  output  1  job aborted by timeout.
REQ-013 bus_wr_en  output  1  accelerator register write strobe.
REQ-014 bus_addr  output  ADDR_W  accelerator register address.
REQ-015 bus_wr_data  output  32  accelerator write data.
REQ-016 bus_rd_data  input  32  accelerator combinational read data for bus_addr.
REQ-017 bus_irq  input  1  accelerator done flag.
REQ-018 jobs_done  output  16  count of completed responses (ok or err).

Function
REQ-019 Register map: CTRL=0 (bit0 start, bit1 clear-done), RESULT=1, OPA=2, OPB=3.
REQ-020 FSM states: IDLE, WR_A, WR_B, START, WAIT_IRQ, CLEAR, RESP; only state encoding + wait counter + operand/result registers hold state.
REQ-021 job_ready = 1 only in IDLE; handshake captures job_a/job_b, IDLE->WR_A.
REQ-022 WR_A: bus_wr_en=1, addr=OPA, data=A; ->WR_B.
REQ-023 WR_B: bus_wr_en=1, addr=OPB, data=B; ->START.
REQ-024 START: bus_wr_en=1, addr=CTRL, data=0x1; clear wait counter; ->WAIT_IRQ.
REQ-025 WAIT_IRQ: bus_wr_en=0, addr=RESULT; if bus_irq=1 capture bus_rd_data into res_data, res_err=0, ->CLEAR; else increment counter.
REQ-026 WAIT_IRQ with bus_irq=0 and counter = TIMEOUT_CYC-1: res_data=0, res_err=1, ->CLEAR.
REQ-027 CLEAR: bus_wr_en=1, addr=CTRL, data=0x2; ->RESP.
REQ-028 RESP: res_valid=1; res_data/res_err stable until res_ready; on handshake jobs_done+1 (wraps 0xFFFF->0x0000), ->IDLE.
REQ-029 Latency with immediate irq: res_valid high 5 cycles after job handshake edge; job_ready high again the cycle after result handshake.
REQ-030 bus_irq stale-high on WAIT_IRQ entry is accepted as done (accelerator updates RESULT on start edge).
REQ-031 Outside write states bus_wr_en=0, bus_wr_data=0; bus_addr=RESULT in WAIT_IRQ, else 0 when not writing.
REQ-032 No arithmetic in this block; 32-bit wrap of result is the accelerator's; width of counter 16 bits.
REQ-033 job_valid ignored outside IDLE; res_ready ignored outside RESP.

Reset
REQ-034 rst_n low asynchronously forces IDLE, counter 0, res_data 0, res_err 0, jobs_done 0.
REQ-035 During reset: job_ready=0, res_valid=0, bus_wr_en=0, bus_addr=0, bus_wr_data=0; job_ready=1 first cycle after release.
REQ-036 Reset mid-job abandons it with no CLEAR write and no response; accelerator state is the reset owner's concern.

Structure
REQ-037 Shared package accel_pkg holds register addresses, CTRL bit positions and the FSM state enum.
REQ-038 Single module, no sub-module; timeout counter inline.

Verification
REQ-039 A=3, B=4, model accelerator -> bus writes 2:3, 3:4, 0:1, 0:2 in order; res_data=7, res_err=0, jobs_done=1.
REQ-040 A=0xFFFFFFFF, B=2 -> res_data=0x00000001, res_err=0.
REQ-041 bus_irq tied 0, TIMEOUT_CYC=8 -> res_valid after 8 WAIT cycles, res_err=1, res_data=0, CTRL clear still written.
REQ-042 res_ready held 0 for 10 cycles -> res_valid/res_data stable, job_ready=0, no bus writes.
REQ-043 rst_n low during WR_B -> bus_wr_en=0 immediately; after release new job A=1,B=1 yields res_data=2.
REQ-044 Two back-to-back jobs with res_ready=1 -> second job_ready 1 cycle after first result; jobs_done=2.
